// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The optional checksum stage is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int WORD_W_DEF = 16;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HI,
    ST_LOAD_LO,
    ST_CHECK,
    ST_LOADED,
    ST_START,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/prog_ram.sv
// Simple dual-port instruction RAM: one synchronous write port and one
// registered read port.
module prog_ram #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; reads of
  // unwritten words are masked by the loader's address-hit flag.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader feeding the CPU instruction port.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  input  logic              run_req,
  input  logic              stop_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_datain,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e AFTER_LAST = ST_CHECK;
`else
  localparam state_e AFTER_LAST = ST_LOADED;
`endif

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              hit_q;
  logic              ram_we;
  logic              accept;
  logic              csum_ok;
  logic [WORD_W-1:0] rdata;

  assign ld_ready   = state_q inside {ST_IDLE, ST_LOAD_HI, ST_LOAD_LO, ST_CHECK};
  assign accept     = ld_valid && ld_ready;
  assign cpu_enable = state_q inside {ST_START, ST_RUN};
  assign cpu_start  = (state_q == ST_START);
  assign busy       = !(state_q inside {ST_IDLE, ST_LOADED});
  assign err        = (state_q == ST_ERR);
  assign word_count = wc_q;
  assign i_datain   = (cpu_enable && hit_q) ? rdata : WORD_W'(NOP_WORD);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running sum restarts with the first byte accepted out of IDLE.
  always_ff @(posedge clock) begin
    if (reset) csum_q <= 8'h00;
    else       csum_q <= (state_q == ST_IDLE ? 8'h00 : csum_q) + (accept ? ld_byte : 8'h00);
  end

  assign csum_ok = ((csum_q + ld_byte) == 8'h00);
`else
  assign csum_ok = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    wc_d    = wc_q;
    ram_we  = 1'b0;
    case (state_q)
      // IDLE takes the first high byte directly, so it advances to the
      // low-byte state to keep the stream bubble-free.
      ST_IDLE, ST_LOAD_HI: begin
        if (accept) begin
          hi_d    = ld_byte;
          state_d = ld_last ? ST_ERR : ST_LOAD_LO;
        end
      end
      ST_LOAD_LO: begin
        if (accept) begin
          if (wc_q == DEPTH) begin
            state_d = ST_ERR;
          end else begin
            ram_we  = 1'b1;
            wc_d    = wc_q + 1'b1;
            state_d = ld_last ? AFTER_LAST : ST_LOAD_HI;
          end
        end
      end
      ST_CHECK: begin
        if (accept) state_d = csum_ok ? ST_LOADED : ST_ERR;
      end
      ST_LOADED: begin
        if (run_req) state_d = ST_START;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          wc_d    = '0;
        end
      end
      default: state_d = ST_ERR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= 8'h00;
      wc_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      wc_q    <= wc_d;
      hit_q   <= ({1'b0, i_addr} < wc_q);
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (wc_q[ADDR_W-1:0]),
    .wdata_i (WORD_W'({hi_q, ld_byte})),
    .raddr_i (i_addr),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default 8-bit address).
// Checksum scenarios are selected by PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_last = 1'b0;
  logic        run_req = 1'b0;
  logic        stop_req = 1'b0;
  logic [7:0]  i_addr = 8'h00;
  logic [15:0] i_datain;
  logic        cpu_enable;
  logic        cpu_start;
  logic [8:0]  word_count;
  logic        busy;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  prog_loader dut (
    .clock      (clock),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .run_req    (run_req),
    .stop_req   (stop_req),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .word_count (word_count),
    .busy       (busy),
    .err        (err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    i_addr = a;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    total_cnt++; if (ld_ready !== 1'b1) $display("FAIL rst_ld_ready got %0b want 1", ld_ready); else pass_cnt++;
    total_cnt++; if (i_datain !== 16'h0000) $display("FAIL rst_i_datain got %h want 0000", i_datain); else pass_cnt++;
    total_cnt++; if ({cpu_enable, cpu_start} !== 2'b00) $display("FAIL rst_cpu got %b want 00", {cpu_enable, cpu_start}); else pass_cnt++;
    total_cnt++; if (word_count !== 9'd0) $display("FAIL rst_word_count got %0d want 0", word_count); else pass_cnt++;
    total_cnt++; if ({busy, err} !== 2'b00) $display("FAIL rst_busy_err got %b want 00", {busy, err}); else pass_cnt++;
  endtask

  task automatic test_load_run();
    do_reset();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00 - 8'h12 - 8'h34 - 8'h56 - 8'h78, 1'b0);
`endif
    total_cnt++; if (word_count !== 9'd2) $display("FAIL load_word_count got %0d want 2", word_count); else pass_cnt++;
    total_cnt++; if ({ld_ready, busy, err} !== 3'b000) $display("FAIL loaded_flags got %b want 000", {ld_ready, busy, err}); else pass_cnt++;
    pulse_run();
    total_cnt++; if ({cpu_start, cpu_enable} !== 2'b11) $display("FAIL start_pulse got %b want 11", {cpu_start, cpu_enable}); else pass_cnt++;
    tick();
    total_cnt++; if ({cpu_start, cpu_enable} !== 2'b01) $display("FAIL run_after_start got %b want 01", {cpu_start, cpu_enable}); else pass_cnt++;
    fetch(8'd0);
    total_cnt++; if (i_datain !== 16'h1234) $display("FAIL fetch_0 got %h want 1234", i_datain); else pass_cnt++;
    fetch(8'd1);
    total_cnt++; if (i_datain !== 16'h5678) $display("FAIL fetch_1 got %h want 5678", i_datain); else pass_cnt++;
    fetch(8'd5);
    total_cnt++; if (i_datain !== 16'h0000) $display("FAIL fetch_5_nop got %h want 0000", i_datain); else pass_cnt++;
    fetch(8'd2);
    total_cnt++; if (i_datain !== 16'h0000) $display("FAIL fetch_2_nop got %h want 0000", i_datain); else pass_cnt++;
    // Bytes offered in RUN must be refused and change nothing.
    send_byte(8'hEE, 1'b1);
    total_cnt++; if ({ld_ready, cpu_enable, word_count} !== {1'b0, 1'b1, 9'd2}) $display("FAIL run_ignores_load got %b/%b/%0d want 0/1/2", ld_ready, cpu_enable, word_count); else pass_cnt++;
  endtask

  task automatic test_stop();
    run_req  = 1'b1;
    stop_req = 1'b1;
    tick();
    run_req  = 1'b0;
    stop_req = 1'b0;
    total_cnt++; if (cpu_enable !== 1'b0) $display("FAIL stop_enable got %0b want 0", cpu_enable); else pass_cnt++;
    total_cnt++; if ({ld_ready, busy, word_count} !== {1'b1, 1'b0, 9'd0}) $display("FAIL stop_idle got %b/%b/%0d want 1/0/0", ld_ready, busy, word_count); else pass_cnt++;
    pulse_run();
    total_cnt++; if ({cpu_start, cpu_enable} !== 2'b00) $display("FAIL idle_run_ignored got %b want 00", {cpu_start, cpu_enable}); else pass_cnt++;
    send_byte(8'h99, 1'b0);
    pulse_run();
    total_cnt++; if ({cpu_start, cpu_enable, busy} !== 3'b001) $display("FAIL partial_run_ignored got %b want 001", {cpu_start, cpu_enable, busy}); else pass_cnt++;
  endtask

  task automatic test_odd_stream();
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b1);
    total_cnt++; if ({err, ld_ready, cpu_enable} !== 3'b100) $display("FAIL odd_err got %b want 100", {err, ld_ready, cpu_enable}); else pass_cnt++;
    pulse_run();
    tick();
    total_cnt++; if ({err, cpu_enable, cpu_start} !== 3'b100) $display("FAIL err_sticky got %b want 100", {err, cpu_enable, cpu_start}); else pass_cnt++;
    do_reset();
    total_cnt++; if ({err, ld_ready} !== 2'b01) $display("FAIL err_cleared got %b want 01", {err, ld_ready}); else pass_cnt++;
  endtask

  task automatic test_reset_midload();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset();
    total_cnt++; if ({word_count, busy} !== {9'd0, 1'b0}) $display("FAIL midload_reset got %0d/%b want 0/0", word_count, busy); else pass_cnt++;
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00 - 8'hCA - 8'hFE, 1'b0);
`endif
    total_cnt++; if ({word_count, busy} !== {9'd1, 1'b0}) $display("FAIL reload_count got %0d/%b want 1/0", word_count, busy); else pass_cnt++;
    pulse_run();
    tick();
    fetch(8'd0);
    total_cnt++; if (i_datain !== 16'hCAFE) $display("FAIL reload_fetch_0 got %h want cafe", i_datain); else pass_cnt++;
    // Old word 0x5678 still sits at address 1 but lies beyond the new count.
    fetch(8'd1);
    total_cnt++; if (i_datain !== 16'h0000) $display("FAIL stale_word_masked got %h want 0000", i_datain); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int w = 0; w < 256; w++) begin
      send_byte(8'(w), 1'b0);
      send_byte(8'(255 - w), 1'b0);
    end
    total_cnt++; if ({word_count, err, busy} !== {9'd256, 1'b0, 1'b1}) $display("FAIL full_count got %0d/%b/%b want 256/0/1", word_count, err, busy); else pass_cnt++;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    total_cnt++; if ({word_count, err} !== {9'd256, 1'b1}) $display("FAIL overflow_err got %0d/%b want 256/1", word_count, err); else pass_cnt++;
    do_reset();
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    total_cnt++; if ({ld_ready, busy, word_count} !== {1'b1, 1'b1, 9'd1}) $display("FAIL check_state got %b/%b/%0d want 1/1/1", ld_ready, busy, word_count); else pass_cnt++;
    send_byte(8'hBA, 1'b1);
    total_cnt++; if ({ld_ready, busy, err} !== 3'b000) $display("FAIL csum_good got %b want 000", {ld_ready, busy, err}); else pass_cnt++;
    do_reset();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'hBB, 1'b0);
    total_cnt++; if ({err, ld_ready} !== 2'b10) $display("FAIL csum_bad got %b want 10", {err, ld_ready}); else pass_cnt++;
  endtask
`else
  task automatic test_checksum();
    do_reset();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    total_cnt++; if ({ld_ready, busy, err, word_count} !== {3'b000, 9'd1}) $display("FAIL direct_loaded got %b%b%b/%0d want 000/1", ld_ready, busy, err, word_count); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_run();
    test_stop();
    test_odd_stream();
    test_reset_midload();
    test_overflow();
    test_checksum();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
